q4_count_capture: RTL and testbench

//  Downstream consumer of the Q4 8-bit counter output (cct_output).

---
 rtl/q4_pkg.sv | 12 +
 rtl/q4_count_capture_if.sv | 13 +
 rtl/q4_sync_fifo.sv | 71 +++++++
 rtl/q4_count_capture.sv | 78 +++++++
 tb/tb_q4_count_capture.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/q4_pkg.sv
// Shared widths and helpers for the Q4 counter capture block.
package q4_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned WRAP_W = 8;

    // True when the counter rolled over from all-ones to zero between two samples.
    function automatic logic is_wrap(input logic [DATA_W-1:0] last, input logic [DATA_W-1:0] cur);
        return (&last) && (cur == '0);
    endfunction

endpackage

// File: rtl/q4_count_capture_if.sv
// Valid/ready read port carrying captured counter values to the next stage.
interface q4_count_capture_if #(
    parameter int unsigned DATA_W = 8
) ();

    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/q4_sync_fifo.sv
// Small synchronous FIFO with a registered show-ahead head and a separate level counter.
module q4_sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W  = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_ptr_nxt;
    logic              do_push;
    logic              do_pop;
    logic [LVL_W-1:0]  level_nxt;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop     = pop && valid;
    assign do_push    = push && (!full || do_pop);
    assign level_nxt  = level + LVL_W'(do_push) - LVL_W'(do_pop);
    assign rd_ptr_nxt = rd_ptr + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            valid  <= 1'b0;
            full   <= 1'b0;
            head   <= '0;
        end else begin
            level <= level_nxt;
            valid <= (level_nxt != '0);
            full  <= (level_nxt == LVL_W'(DEPTH));
            if (do_push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            // Head follows the next stored entry, or the incoming one when the queue drains to it.
            if (do_pop) begin
                if (level > LVL_W'(1)) begin
                    head <= mem[rd_ptr_nxt];
                end else if (do_push) begin
                    head <= push_data;
                end
            end else if (do_push && (level == '0)) begin
                head <= push_data;
            end
        end
    end

endmodule

// File: rtl/q4_count_capture.sv
// Samples the upstream Q4 counter on a prescaled tick, queues changed values, counts wraps.
module q4_count_capture #(
    parameter int unsigned DATA_W     = q4_pkg::DATA_W,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned SAMPLE_DIV = 2
) (
    input  logic                        clk,
    input  logic                        clear,
    input  logic [DATA_W-1:0]           cct_value,
    q4_count_capture_if.master          rd,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        overflow,
    output logic [q4_pkg::WRAP_W-1:0]   wrap_count
);

    import q4_pkg::*;

    localparam int unsigned PRE_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SAMPLE_DIV - 1);

    logic [PRE_W-1:0]  prescaler;
    logic [DATA_W-1:0] last_sample;
    logic              first_flag;
    logic              tick;
    logic              push_req;
    logic              wrap;
    logic              pop;
    logic              fifo_full;
    logic              fifo_valid;
    logic [DATA_W-1:0] fifo_head;

    assign tick     = (prescaler == PRE_LAST);
    assign push_req = tick && (first_flag || (cct_value != last_sample));
    assign wrap     = tick && !first_flag && is_wrap(last_sample, cct_value);
    assign pop      = fifo_valid && rd.ready;

    assign rd.valid = fifo_valid;
    assign rd.data  = fifo_head;

    always_ff @(posedge clk) begin
        if (clear) begin
            prescaler   <= '0;
            last_sample <= '0;
            first_flag  <= 1'b1;
            overflow    <= 1'b0;
            wrap_count  <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PRE_W'(1);
            if (tick) begin
                last_sample <= cct_value;
                first_flag  <= 1'b0;
            end
            if (wrap && (wrap_count != '1)) begin
                wrap_count <= wrap_count + WRAP_W'(1);
            end
            // Sticky: a changed sample arrived with nowhere to go.
            if (push_req && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    q4_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .clear     (clear),
        .push      (push_req),
        .push_data (cct_value),
        .pop       (pop),
        .head      (fifo_head),
        .valid     (fifo_valid),
        .full      (fifo_full),
        .level     (level)
    );

endmodule

// File: tb/tb_q4_count_capture.sv
// Bench for q4_count_capture: two instances (sample divider 2 and 1) against a queue-level model.
module tb_q4_count_capture;

    logic       clk = 1'b0;
    logic       clear;
    logic [7:0] cct_value;
    logic       rd_ready;

    q4_count_capture_if #(.DATA_W(8)) rd0 ();
    q4_count_capture_if #(.DATA_W(8)) rd1 ();

    logic [2:0] level0, level1;
    logic       ovf0, ovf1;
    logic [7:0] wrap0, wrap1;

    assign rd0.ready = rd_ready;
    assign rd1.ready = rd_ready;

    always #5 clk = ~clk;

    q4_count_capture #(.DATA_W(8), .DEPTH(4), .SAMPLE_DIV(2)) u_div2 (
        .clk(clk), .clear(clear), .cct_value(cct_value), .rd(rd0),
        .level(level0), .overflow(ovf0), .wrap_count(wrap0)
    );

    q4_count_capture #(.DATA_W(8), .DEPTH(4), .SAMPLE_DIV(1)) u_div1 (
        .clk(clk), .clear(clear), .cct_value(cct_value), .rd(rd1),
        .level(level1), .overflow(ovf1), .wrap_count(wrap1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: per-instance cycle count since clear, sample history, and a plain list of queued values.
    int         div_of [2] = '{2, 1};
    bit         known = 1'b0;
    int         m_cyc   [2];
    logic [7:0] m_last  [2];
    bit         m_first [2];
    logic [7:0] m_buf   [2][4];
    int         m_cnt   [2];
    logic [7:0] m_shown [2];
    bit         m_ovf   [2];
    int         m_wraps [2];

    task automatic model_update(input logic c, input logic [7:0] v, input logic r);
        for (int k = 0; k < 2; k++) begin
            if (c) begin
                m_cyc[k] = 0; m_last[k] = 8'h00; m_first[k] = 1'b1; m_cnt[k] = 0;
                m_shown[k] = 8'h00; m_ovf[k] = 1'b0; m_wraps[k] = 0;
            end else begin
                bit pop_m, tick_m, push_m;
                pop_m  = (m_cnt[k] > 0) && r;
                tick_m = (m_cyc[k] % div_of[k]) == div_of[k] - 1;
                m_cyc[k]++;
                push_m = tick_m && (m_first[k] || v != m_last[k]);
                if (tick_m && !m_first[k] && m_last[k] == 8'hFF && v == 8'h00 && m_wraps[k] < 255)
                    m_wraps[k]++;
                if (tick_m) begin
                    m_last[k]  = v;
                    m_first[k] = 1'b0;
                end
                if (pop_m) begin
                    for (int i = 0; i < 3; i++) m_buf[k][i] = m_buf[k][i+1];
                    m_cnt[k]--;
                end
                if (push_m) begin
                    if (m_cnt[k] < 4) begin
                        m_buf[k][m_cnt[k]] = v;
                        m_cnt[k]++;
                    end else begin
                        m_ovf[k] = 1'b1;
                    end
                end
                if (m_cnt[k] > 0) m_shown[k] = m_buf[k][0];
            end
        end
        if (c) known = 1'b1;
    endtask

    task automatic compare_all();
        if (known) begin
            check("d2_valid", 32'(rd0.valid), 32'(m_cnt[0] > 0));
            check("d2_data",  32'(rd0.data),  32'(m_shown[0]));
            check("d2_level", 32'(level0),    32'(m_cnt[0]));
            check("d2_ovf",   32'(ovf0),      32'(m_ovf[0]));
            check("d2_wrap",  32'(wrap0),     32'(m_wraps[0]));
            check("d1_valid", 32'(rd1.valid), 32'(m_cnt[1] > 0));
            check("d1_data",  32'(rd1.data),  32'(m_shown[1]));
            check("d1_level", 32'(level1),    32'(m_cnt[1]));
            check("d1_ovf",   32'(ovf1),      32'(m_ovf[1]));
            check("d1_wrap",  32'(wrap1),     32'(m_wraps[1]));
        end
    endtask

    // Check outputs of the previous edge, then present inputs for the next one.
    task automatic step(input logic c, input logic [7:0] v, input logic r);
        @(negedge clk);
        compare_all();
        clear = c; cct_value = v; rd_ready = r;
        model_update(c, v, r);
    endtask

    logic [7:0] vals [6];

    initial begin
        clear = 1'b1; cct_value = 8'h00; rd_ready = 1'b0;
        model_update(1'b1, 8'h00, 1'b0);

        // Constant value: exactly one entry, then empty.
        step(1'b1, 8'h05, 1'b1);
        step(1'b0, 8'h05, 1'b1);
        check("reset_level", 32'(level0), 32'd0);
        check("reset_wrap",  32'(wrap0),  32'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h05, 1'b1);

        // Rollover across successive ticks.
        for (int i = 0; i < 3; i++) begin
            logic [7:0] seq [3];
            seq = '{8'hFE, 8'hFF, 8'h00};
            step(1'b0, seq[i], 1'b1);
            step(1'b0, seq[i], 1'b1);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
        check("t2_wrap", 32'(wrap0), 32'd1);

        // Fill past capacity with no reader, then drain in order.
        for (int i = 0; i < 6; i++) vals[i] = 8'(8'h10 + 8'(i * 3));
        for (int i = 0; i < 6; i++) begin
            step(1'b0, vals[i], 1'b0);
            step(1'b0, vals[i], 1'b0);
        end
        step(1'b0, vals[5], 1'b0);
        check("t3_level", 32'(level0), 32'd4);
        check("t3_ovf",   32'(ovf0),   32'd1);
        for (int j = 0; j < 4; j++) begin
            step(1'b0, vals[5], 1'b1);
            check("t3_pop", 32'(rd0.data), 32'(vals[j]));
        end
        step(1'b0, vals[5], 1'b1);

        // Full FIFO, one pop coinciding with a push on the tick.
        step(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'(8'h40 + 8'(i)), 1'b0);
            step(1'b0, 8'(8'h40 + 8'(i)), 1'b0);
        end
        step(1'b0, 8'h40 + 8'h03, 1'b0);
        step(1'b0, 8'h77, (m_cyc[0] % 2) == 1);
        step(1'b0, 8'h77, 1'b0);
        step(1'b0, 8'h77, 1'b0);
        check("t4_level", 32'(level0), 32'd4);
        check("t4_ovf",   32'(ovf0),   32'd0);

        // Clear mid-stream; first tick afterwards pushes an unchanged value.
        step(1'b0, 8'hFF, 1'b0);
        step(1'b0, 8'hFF, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("t5_level", 32'(level0), 32'd0);
        check("t5_valid", 32'(rd0.valid), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("t5_push", 32'(level0), 32'd1);

        // Divider 1 instance sees every value of a free-running count.
        step(1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b0, 8'(i), 1'b1);
        step(1'b0, 8'(300), 1'b1);
        check("t6_wrap", 32'(wrap1), 32'd1);
        check("t6_ovf",  32'(ovf1),  32'd0);

        // Random values from a narrow set so repeats and rollovers are frequent.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] v;
            int sel;
            sel = $urandom_range(0, 5);
            v = (sel == 0) ? 8'hFF : (sel == 1) ? 8'h00 : 8'($urandom_range(1, 3));
            step(($urandom_range(0, 99) < 2), v, ($urandom_range(0, 2) == 0));
        end
        step(1'b0, 8'h00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
